// File: rtl/sysid_reader_pkg.sv
// Shared types and constants for the system ID reader: FSM states, word
// addresses of the ID peripheral, and the default expected contents.
package sysid_reader_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ID_REQ,
        ID_WAIT,
        TS_REQ,
        TS_WAIT,
        FIN
    } state_t;

    localparam logic ID_WORD_ADDR = 1'b0;
    localparam logic TS_WORD_ADDR = 1'b1;

    localparam logic [31:0] DEFAULT_EXPECTED_ID        = 32'h4352_0D20;
    localparam logic [31:0] DEFAULT_EXPECTED_TIMESTAMP = 32'h4C34_24BF;
    localparam int          DEFAULT_TIMEOUT_CYCLES     = 255;

endpackage

// File: rtl/sysid_reader_timeout.sv
// Per-transaction watchdog: a loadable up-counter that flags when it has
// counted LIMIT cycles since it was last cleared.
module sysid_reader_timeout #(
    parameter int LIMIT = 255
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         i_clear,
    input  logic                         i_load,
    input  logic [$clog2(LIMIT+1)-1:0]   i_loadValue,
    input  logic                         i_enable,
    output logic                         o_expired
);

    localparam int CW = $clog2(LIMIT + 1);

    logic [CW-1:0] r_count;

    // Clear beats load beats count; the owner stops enabling once expired,
    // so the counter never needs to wrap.
    always_ff @(posedge clock) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_loadValue;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_expired = (r_count == CW'(LIMIT));

endmodule

// File: rtl/sysid_reader.sv
// Avalon-MM read master that fetches the system ID and build timestamp words
// and reports whether they match the expected values.
module sysid_reader
    import sysid_reader_pkg::*;
#(
    parameter logic [31:0] EXPECTED_ID        = DEFAULT_EXPECTED_ID,
    parameter logic [31:0] EXPECTED_TIMESTAMP = DEFAULT_EXPECTED_TIMESTAMP,
    parameter int          TIMEOUT_CYCLES     = DEFAULT_TIMEOUT_CYCLES
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    input  logic        avm_readdatavalid,
    output logic        busy,
    output logic        done,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout_err,
    output logic [31:0] id_value,
    output logic [31:0] ts_value
);

    state_t      r_state;
    logic        r_address;
    logic        r_read;
    logic        r_busy;
    logic        r_done;
    logic        r_idOk;
    logic        r_tsOk;
    logic        r_timeoutErr;
    logic [31:0] r_idValue;
    logic [31:0] r_tsValue;

    logic w_accept;
    logic w_inXfer;
    logic w_idCapture;
    logic w_tsCapture;
    logic w_tmrClear;
    logic w_expired;

    assign w_accept    = r_read && !avm_waitrequest;
    assign w_inXfer    = (r_state == ID_REQ) || (r_state == ID_WAIT) ||
                         (r_state == TS_REQ) || (r_state == TS_WAIT);
    // Data counts in a WAIT state, or in the acceptance cycle of a REQ state.
    assign w_idCapture = avm_readdatavalid &&
                         ((r_state == ID_WAIT) || ((r_state == ID_REQ) && w_accept));
    assign w_tsCapture = avm_readdatavalid &&
                         ((r_state == TS_WAIT) || ((r_state == TS_REQ) && w_accept));
    assign w_tmrClear  = !w_inXfer || w_idCapture;

    sysid_reader_timeout #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clock       (clock),
        .reset       (reset),
        .i_clear     (w_tmrClear),
        .i_load      (1'b0),
        .i_loadValue ('0),
        .i_enable    (w_inXfer),
        .o_expired   (w_expired)
    );

    // Captured data takes priority over an expiring watchdog in the same cycle.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= IDLE;
            r_address    <= ID_WORD_ADDR;
            r_read       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_idOk       <= 1'b0;
            r_tsOk       <= 1'b0;
            r_timeoutErr <= 1'b0;
            r_idValue    <= '0;
            r_tsValue    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_idOk       <= 1'b0;
                        r_tsOk       <= 1'b0;
                        r_timeoutErr <= 1'b0;
                        r_idValue    <= '0;
                        r_tsValue    <= '0;
                        r_busy       <= 1'b1;
                        r_read       <= 1'b1;
                        r_address    <= ID_WORD_ADDR;
                        r_state      <= ID_REQ;
                    end
                end
                ID_REQ, ID_WAIT: begin
                    if (w_idCapture) begin
                        r_idValue <= avm_readdata;
                        r_idOk    <= (avm_readdata == EXPECTED_ID);
                        r_read    <= 1'b1;
                        r_address <= TS_WORD_ADDR;
                        r_state   <= TS_REQ;
                    end else if (w_expired) begin
                        r_timeoutErr <= 1'b1;
                        r_read       <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= FIN;
                    end else if (w_accept) begin
                        r_read  <= 1'b0;
                        r_state <= ID_WAIT;
                    end
                end
                TS_REQ, TS_WAIT: begin
                    if (w_tsCapture) begin
                        r_tsValue <= avm_readdata;
                        r_tsOk    <= (avm_readdata == EXPECTED_TIMESTAMP);
                        r_read    <= 1'b0;
                        r_busy    <= 1'b0;
                        r_done    <= 1'b1;
                        r_state   <= FIN;
                    end else if (w_expired) begin
                        r_timeoutErr <= 1'b1;
                        r_read       <= 1'b0;
                        r_busy       <= 1'b0;
                        r_done       <= 1'b1;
                        r_state      <= FIN;
                    end else if (w_accept) begin
                        r_read  <= 1'b0;
                        r_state <= TS_WAIT;
                    end
                end
                FIN: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign avm_address = r_address;
    assign avm_read    = r_read;
    assign busy        = r_busy;
    assign done        = r_done;
    assign id_ok       = r_idOk;
    assign ts_ok       = r_tsOk;
    assign timeout_err = r_timeoutErr;
    assign id_value    = r_idValue;
    assign ts_value    = r_tsValue;

endmodule
